// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_MIN    = 1;
  localparam int LAT_MAX    = 15;
  localparam int LAT_CNT_W  = 4;

  // Error-cause bit positions, reserved for a future status register.
  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: per-byte write enables, registered read, no reset.
import mem_pkg::*;

module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // One byte-wide array per lane keeps each lane's storage single-driven.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (be[i]) mem[addr] <= wdata[8*i +: 8];
      if (re)    rd_q      <= mem[addr];
    end

    assign rdata[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage memory responder: one request at a time, fixed-latency response,
// error screening and saturating load/store counters.
import mem_pkg::*;

module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_stall,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam logic [LAT_CNT_W-1:0] CNT_INIT =
    LAT_CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic                 op_err_q, op_err_d;
  logic                 rv_q, rv_d;
  logic                 err_q, err_d;
  logic                 ld_q, ld_d;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;

  logic        accept, req_err;
  logic        ram_re;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;

  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_err   = (|req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);
  assign ram_re    = accept & ~req_we & ~req_err;
  assign ram_be    = (accept & req_we & ~req_err) ? req_be : 4'b0000;

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (req_addr[ADDR_W+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    op_err_d = op_err_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    ld_d     = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        we_d     = req_we;
        op_err_d = req_err;
        if (LATENCY == 1 || req_err) begin
          state_d = RESP;
          rv_d    = 1'b1;
          err_d   = req_err;
          ld_d    = ~req_we & ~req_err;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        rv_d    = 1'b1;
        err_d   = op_err_q;
        ld_d    = ~we_q & ~op_err_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (!op_err_q) begin
          if (we_q) wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 1'b1;
          else      rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      op_err_q <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      ld_q     <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      op_err_q <= op_err_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      ld_q     <= ld_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // The RAM read register holds the snapshot; ld_q exposes it only in RESP.
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = ld_q ? ram_rdata : 32'h0;
  assign mem_stall  = req_valid & ~resp_valid;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's memory-stage load/store requests; it sits between the datapath's M-stage outputs (address, store data) and a word-organised data RAM.
- Accepts one request at a time over a valid/ready handshake. Performs the store, or snapshots the load word, and returns a response after a fixed latency.
- Drives a stall signal that the hazard unit ORs into stallF/stallD and the E/M freeze.

Parameters:
- ADDR_W, 10, word-index width; RAM depth = 2**ADDR_W words; legal byte addresses are 0 .. 4*(2**ADDR_W)-1.
- LATENCY, 2, cycles from the accept cycle to the response cycle; legal range 1..15.
- CNT_W, 16, width of the saturating read/write performance counters.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, 1, request present; the requester holds it and all req_* stable until resp_valid.
- req_we, input, 1, 1 = store, 0 = load.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data.
- req_be, input, 4, byte-lane write enables; lane i = bits [8i+7:8i]; ignored for loads.
- req_ready, output, 1, responder idle and able to accept.
- resp_valid, output, 1, one-cycle response strobe.
- resp_rdata, output, 32, load data; 0 for stores and errors.
- resp_err, output, 1, request was misaligned or out of range.
- mem_stall, output, 1, req_valid & ~resp_valid; combinational.
- rd_count, output, CNT_W, successful loads completed; saturating.
- wr_count, output, CNT_W, successful stores completed; saturating.

Behaviour:
- Reset: a clock edge with rst=1 forces the following:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - latency counter = 0; rd_count = wr_count = 0.
  - The RAM array is not cleared.
- req_ready = (state==IDLE) & ~rst.
- Accept: a request is accepted on an edge where req_valid & req_ready.
- States:
  - IDLE: on accept, go to RESP if LATENCY==1 or the request errors; otherwise load cnt=LATENCY-2 and go to WAIT.
  - WAIT: cnt decrements each cycle; at cnt==0 go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE unconditionally; req_ready=0 in RESP.
- Timing: resp_valid is high in the cycle LATENCY cycles after the accept cycle, or 1 cycle after for errors. The minimum request-to-request spacing is LATENCY+1 cycles.
- Error check, evaluated at accept:
  - misaligned when req_addr[1:0]!=0;
  - out of range when req_addr[31:ADDR_W+2]!=0;
  - on error: no RAM access, resp_err=1, resp_rdata=0, no counter increment.
- Store:
  - RAM word req_addr[ADDR_W+1:2] is written on the accept edge, only the lanes where req_be=1;
  - req_be=0000 is legal: no data change, but it still counts in wr_count;
  - response carries resp_rdata=0, resp_err=0.
- Load:
  - the word is read on the accept edge and held in a response register until the response cycle;
  - later stores cannot alter it, since none can be accepted meanwhile.
- Response outputs: resp_rdata and resp_err are registered, valid only while resp_valid=1, and return to 0 in the cycle after.
- Counters: incremented in the response cycle; they saturate at 2**CNT_W-1 and never wrap.
- Requester behaviour:
  - The requester must drop req_valid or present a new request in the cycle after resp_valid.
  - If req_valid is still high in the IDLE cycle after a response, it is treated as a new request.
  - req_valid dropping mid-request (protocol violation) does not abort the transaction.
- Reset mid-operation: a pending response is discarded and no resp_valid is issued. A store accepted before the reset edge remains committed.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, WAIT, RESP);
  - constants WORD_BYTES=4 and the legal-LATENCY range;
  - an error-cause localparam pair (ERR_ALIGN, ERR_RANGE), reserved for future status reporting.
- One sub-module, dmem_ram:
  - 2**ADDR_W x 32 array with per-byte write enables and synchronous read;
  - no reset;
  - instantiated once.
- FSM, latency counter, error check and performance counters stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - stimulus: store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10;
  - required: each resp_valid arrives 2 cycles after its accept; load returns 0xDEADBEEF; wr_count=1, rd_count=1.
- Byte lanes:
  - stimulus: preload 0x11223344 at 0x20; store wdata 0xAABBCCDD, be 0101; then load;
  - required: 0x11BB33DD.
- Errors:
  - misaligned load 0x22: resp_err=1, rdata=0, 1-cycle response, counters unchanged;
  - store to 0x00001000 with ADDR_W=10: resp_err=1 and RAM unchanged.
- Back-to-back with req_valid held high across 3 loads:
  - req_ready low in WAIT/RESP;
  - accepts exactly LATENCY+1=3 cycles apart;
  - mem_stall low only in response cycles.
- Reset mid-read:
  - stimulus: assert rst in the WAIT cycle;
  - required: no resp_valid; req_ready=1 the cycle after rst drops; a prior store to 0x30 still reads back intact.
- Saturation with CNT_W=2:
  - stimulus: 5 successful loads;
  - required: rd_count holds 3; an error load leaves it at 3.
